// File: rtl/fire_sched_pkg.sv
// fire_sched_pkg: shared types and helpers for the fire scheduler.
package fire_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STABLE = 2'd2,
        HALT   = 2'd3
    } sched_state_t;

    // Index value on `fire` meaning "no transition selected".
    function automatic int unsigned idle_code(input int unsigned n);
        return n;
    endfunction

    // Increment that sticks at `max` instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/fire_scheduler_if.sv
// fire_scheduler_if: scheduling request/response bundle between the
// simulated netlist (master) and the scheduler (slave).
interface fire_scheduler_if #(
    parameter int N  = 8,
    parameter int FW = $clog2(N+1),
    parameter int CW = 16
);
    logic          run;
    logic [N-1:0]  excited;
    logic          force_valid;
    logic [FW-1:0] force_idx;
    logic [FW-1:0] fire;
    logic          fired;
    logic          stable;
    logic          halted;
    logic          force_err;
    logic [CW-1:0] fire_count;
    logic          starve;
    logic [FW-1:0] starve_idx;

    modport master (
        output run, excited, force_valid, force_idx,
        input  fire, fired, stable, halted, force_err, fire_count, starve, starve_idx
    );

    modport slave (
        input  run, excited, force_valid, force_idx,
        output fire, fired, stable, halted, force_err, fire_count, starve, starve_idx
    );
endinterface

// File: rtl/fire_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker. The request vector is
// duplicated, indices below ptr in the low copy are masked off, and the
// lowest surviving bit wins; a hit in the high copy is the wrap-around case.
module rr_pick #(
    parameter int N  = 8,
    parameter int FW = $clog2(N+1)
) (
    input  logic [N-1:0]  req,
    input  logic [FW-1:0] ptr,
    output logic [FW-1:0] grant_idx,
    output logic          grant_valid
);
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;

    assign dbl = {req, req};

    // Mask below ptr, then lowest-index priority search over both copies.
    always_comb begin
        masked      = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < 2*N; i++) begin
            masked[i] = dbl[i] && (i >= int'(ptr));
        end
        for (int i = 2*N-1; i >= 0; i--) begin
            if (masked[i]) begin
                grant_valid = 1'b1;
                grant_idx   = FW'((i >= N) ? (i - N) : i);
            end
        end
    end
endmodule

// File: rtl/fire_scheduler.sv
// fire_scheduler: picks at most one excited transition per cycle (forced or
// round-robin) to drive the netlist's `fire` index. Zero-latency selection.
// Optional starvation watchdog enabled by FIRE_SCHED_WATCHDOG_EN.
module fire_scheduler
    import fire_sched_pkg::*;
#(
    parameter int N     = 8,
    parameter int FW    = $clog2(N+1),
    parameter int CW    = 16,
    parameter int LIMIT = 32
) (
    input  logic clk,
    input  logic reset,
    fire_scheduler_if.slave bus
);
    localparam logic [FW-1:0] IDLE_IDX = FW'(idle_code(N));
    localparam logic [31:0]   CNT_MAX  = 32'({CW{1'b1}});

    sched_state_t  state;
    logic [FW-1:0] ptr;
    logic [FW-1:0] grant_idx;
    logic          grant_valid;
    logic          active;
    logic          force_ok;
    logic          force_bad;
    logic [FW-1:0] fire;
    logic          fired;
    logic [CW-1:0] fire_count;
    logic          force_err;
    logic          starve_hit;
    logic          starve;
    logic [FW-1:0] starve_idx;

    rr_pick #(.N(N), .FW(FW)) u_pick (
        .req        (bus.excited),
        .ptr        (ptr),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    // Selection is live only in RUN/STABLE with run held; reset forces IDLE
    // state asynchronously, so fire drops to idle within the same cycle.
    assign active    = bus.run && (state == RUN || state == STABLE);
    assign force_ok  = active && bus.force_valid && (bus.force_idx <  IDLE_IDX);
    assign force_bad = active && bus.force_valid && (bus.force_idx >= IDLE_IDX);

    // Forced index wins; a bad force yields idle; otherwise round-robin.
    always_comb begin
        fire = IDLE_IDX;
        if (force_ok)
            fire = bus.force_idx;
        else if (active && !bus.force_valid && grant_valid)
            fire = grant_idx;
    end

    assign fired = (fire != IDLE_IDX);

`ifdef FIRE_SCHED_WATCHDOG_EN
    localparam int AW = $clog2(LIMIT+1);

    logic [N-1:0][AW-1:0] age;
    logic [N-1:0]         hit;
    logic [FW-1:0]        hit_idx;

    // A transition starves on the edge where its age would reach LIMIT.
    always_comb begin
        hit     = '0;
        hit_idx = '0;
        for (int i = 0; i < N; i++) begin
            hit[i] = active && bus.excited[i] && !(fired && fire == FW'(i))
                     && (age[i] == AW'(LIMIT-1));
        end
        for (int i = N-1; i >= 0; i--) begin
            if (hit[i]) hit_idx = FW'(i);
        end
    end

    assign starve_hit = |hit;

    // Age counters run only while scheduling; first starved index is latched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age        <= '0;
            starve     <= 1'b0;
            starve_idx <= '0;
        end else if (active) begin
            for (int i = 0; i < N; i++) begin
                if (bus.excited[i] && !(fired && fire == FW'(i)))
                    age[i] <= (age[i] == AW'(LIMIT)) ? age[i] : age[i] + AW'(1);
                else
                    age[i] <= '0;
            end
            if (starve_hit && !starve) begin
                starve     <= 1'b1;
                starve_idx <= hit_idx;
            end
        end
    end
`else
    assign starve_hit = 1'b0;
    assign starve     = 1'b0;
    assign starve_idx = '0;
`endif

    // Scheduler FSM; HALT is only left through reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:        if (bus.run) state <= RUN;
                RUN, STABLE: begin
                    if (force_bad || starve_hit) state <= HALT;
                    else if (!bus.run)           state <= IDLE;
                    else if (bus.excited == '0)  state <= STABLE;
                    else                         state <= RUN;
                end
                default:     state <= HALT;
            endcase
        end
    end

    // Round-robin pointer, saturating fire counter and sticky force error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr        <= '0;
            fire_count <= '0;
            force_err  <= 1'b0;
        end else begin
            if (active && !bus.force_valid && grant_valid)
                ptr <= (grant_idx == FW'(N-1)) ? '0 : grant_idx + FW'(1);
            if (fired)
                fire_count <= CW'(sat_inc(32'(fire_count), CNT_MAX));
            if (force_bad)
                force_err <= 1'b1;
        end
    end

    assign bus.fire       = fire;
    assign bus.fired      = fired;
    assign bus.stable     = (state == STABLE);
    assign bus.halted     = (state == HALT);
    assign bus.force_err  = force_err;
    assign bus.fire_count = fire_count;
    assign bus.starve     = starve;
    assign bus.starve_idx = starve_idx;
endmodule

// File: tb/tb_fire_scheduler.sv
// tb_fire_scheduler: directed stimulus with a cycle-stamped expectation queue;
// a negedge monitor pops and compares the entries due in the current cycle.
// CW is kept small so fire_count saturation is reached.
module tb_fire_scheduler;
    localparam int N = 8, FW = 4, CW = 3, LIMIT = 4;

    typedef enum int {K_FIRE, K_FIRED, K_STABLE, K_HALT, K_FERR, K_CNT, K_STARVE, K_SIDX} kind_t;
    typedef struct {
        int    cyc;
        string name;
        kind_t kind;
        int    exp;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    logic clk    = 1'b0;
    logic reset  = 1'b0;

    fire_scheduler_if #(.N(N), .FW(FW), .CW(CW)) bus ();

    fire_scheduler #(.N(N), .FW(FW), .CW(CW), .LIMIT(LIMIT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(input kind_t k);
        case (k)
            K_FIRE:   return int'(bus.fire);
            K_FIRED:  return int'(bus.fired);
            K_STABLE: return int'(bus.stable);
            K_HALT:   return int'(bus.halted);
            K_FERR:   return int'(bus.force_err);
            K_CNT:    return int'(bus.fire_count);
            K_STARVE: return int'(bus.starve);
            default:  return int'(bus.starve_idx);
        endcase
    endfunction

    // Monitor: compare every expectation stamped for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            int   a;
            e = q.pop_front();
            a = actual(e.kind);
            n_cmp++;
            if (e.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else if ($isunknown(bus.fire) || a != e.exp) begin
                n_bad++;
                $display("FAIL %s (cycle %0d): got %0d, want %0d", e.name, cyc, a, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input kind_t k, input int v);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.kind = k;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [N-1:0] ex, input logic fv, input logic [FW-1:0] fi);
        bus.run         = r;
        bus.excited     = ex;
        bus.force_valid = fv;
        bus.force_idx   = fi;
    endtask

    initial begin
        int seq [5] = '{0, 2, 7, 0, 2};

        drive(1'b0, 8'hFF, 1'b0, 4'd0);

        // Reset held with everything excited.
        tick();
        push("rst_fire", K_FIRE, 8);      push("rst_fired", K_FIRED, 0);
        push("rst_stable", K_STABLE, 0);  push("rst_halted", K_HALT, 0);
        push("rst_ferr", K_FERR, 0);      push("rst_cnt", K_CNT, 0);
        push("rst_starve", K_STARVE, 0);  push("rst_sidx", K_SIDX, 0);
        tick(); reset = 1'b1;
        push("rel_fire", K_FIRE, 8);
        tick();
        push("idle_fire", K_FIRE, 8);     push("idle_stable", K_STABLE, 0);
        push("idle_halted", K_HALT, 0);

        // Round-robin over 8'b1000_0101.
        tick(); drive(1'b1, 8'h85, 1'b0, 4'd0);
        push("idle_to_run_fire", K_FIRE, 8);
        for (int i = 0; i < 5; i++) begin
            tick();
            push($sformatf("rr_fire%0d", i), K_FIRE, seq[i]);
            push($sformatf("rr_cnt%0d", i), K_CNT, i);
        end

        // Move ptr to 6, then wrap-around grant, then quiesce.
        tick(); bus.excited = 8'h20;
        push("rr_cnt5", K_CNT, 5);        push("to_ptr6_fire", K_FIRE, 5);
        tick(); bus.excited = 8'h02;
        push("wrap_fire", K_FIRE, 1);
        tick(); bus.excited = 8'h00;
        push("quiet_fire", K_FIRE, 8);    push("quiet_fired", K_FIRED, 0);
        push("quiet_stable_lag", K_STABLE, 0);
        tick();
        push("stable_set", K_STABLE, 1);  push("stable_fire", K_FIRE, 8);
        push("cnt_sat", K_CNT, 7);
        tick(); bus.excited = 8'h08;
        push("reexcite_fire", K_FIRE, 3); push("reexcite_stable", K_STABLE, 1);
        tick();
        push("back_to_run", K_STABLE, 0); push("run_wrap_fire", K_FIRE, 3);

        // Forces leave ptr (4) alone.
        tick(); drive(1'b1, 8'h00, 1'b1, 4'd3);
        push("force3_fire", K_FIRE, 3);
        tick(); bus.force_idx = 4'd6;
        push("force6_fire", K_FIRE, 6);
        tick(); drive(1'b1, 8'h3F, 1'b0, 4'd0);
        push("ptr_kept_fire", K_FIRE, 4); push("force_stable", K_STABLE, 1);
        push("cnt_held_sat", K_CNT, 7);

        // Out-of-range force.
        tick(); drive(1'b1, 8'h00, 1'b1, 4'd9);
        push("badforce_fire", K_FIRE, 8); push("badforce_fired", K_FIRED, 0);
        push("badforce_ferr_lag", K_FERR, 0);
        tick(); drive(1'b1, 8'hFF, 1'b0, 4'd0);
        push("halt_set", K_HALT, 1);      push("ferr_set", K_FERR, 1);
        push("halt_fire", K_FIRE, 8);
        tick(); bus.run = 1'b0;
        push("halt_sticky", K_HALT, 1);   push("halt_norun_fire", K_FIRE, 8);

        // Starvation: index 5 excited while index 0 is forced.
        tick(); reset = 1'b0;
        push("rst2_halted", K_HALT, 0);   push("rst2_ferr", K_FERR, 0);
        push("rst2_cnt", K_CNT, 0);       push("rst2_fire", K_FIRE, 8);
        tick(); reset = 1'b1; drive(1'b1, 8'h20, 1'b1, 4'd0);
        push("wd_idle_fire", K_FIRE, 8);
        for (int i = 0; i < 4; i++) begin
            tick();
            push($sformatf("wd_force_fire%0d", i), K_FIRE, 0);
            push($sformatf("wd_no_starve%0d", i), K_STARVE, 0);
        end
        tick();
`ifdef FIRE_SCHED_WATCHDOG_EN
        push("wd_starve", K_STARVE, 1);   push("wd_sidx", K_SIDX, 5);
        push("wd_halted", K_HALT, 1);     push("wd_fire", K_FIRE, 8);
`else
        push("nowd_starve", K_STARVE, 0); push("nowd_sidx", K_SIDX, 0);
        push("nowd_halted", K_HALT, 0);   push("nowd_fire", K_FIRE, 0);
`endif

        // Reset in the middle of a grant of index 4.
        tick(); reset = 1'b0; drive(1'b0, 8'h00, 1'b0, 4'd0);
        push("rst3_starve", K_STARVE, 0); push("rst3_fire", K_FIRE, 8);
        tick(); reset = 1'b1; drive(1'b1, 8'h10, 1'b0, 4'd0);
        push("mid_idle_fire", K_FIRE, 8);
        tick();
        push("mid_grant4", K_FIRE, 4);
        tick(); reset = 1'b0;
        push("mid_rst_fire", K_FIRE, 8);  push("mid_rst_fired", K_FIRED, 0);
        push("mid_rst_cnt", K_CNT, 0);
        tick(); reset = 1'b1; bus.excited = 8'h30;
        push("post_idle_fire", K_FIRE, 8);
        tick();
        push("post_ptr0_fire", K_FIRE, 4); push("post_cnt", K_CNT, 0);

        repeat (3) tick();
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
            n_bad += q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
